ex_stage_md: RTL
================

# ex_stage_md

Parametrised execute stage for the pipelined MIPS core, with the EX/MEM pipeline register folded in. It keeps the operand-forwarding muxes, the ALUSrc mux and the ALU. It adds an iterative unsigned multiply/divide unit with HI/LO registers and an internal stall generator. It sits between the ID/EX register and the memory stage, and it drives the hazard unit through `StallE`.

## Interface

- `WIDTH`, 32, datapath width (≥ 8, even)
- `REGW`, 5, register-address width
- `CNTW`, 6, iteration-counter width, ≥ clog2(WIDTH)+1
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `RD1_E`, `RD2_E` in WIDTH: register-file operands
- `SignImmE` in WIDTH: sign-extended immediate
- `ResultW` in WIDTH: writeback result, forwarding source
- `ForwardAE`, `ForwardBE` in 2: forwarding select; 00 = RD, 01 = ResultW, 10 = ALUOutM, 11 = RD
- `RtE`, `RdE` in REGW: destination candidates
- `RegDstE`, `ALUSrcE`, `RegWriteE` in 1: decoded controls
- `ALUControlE` in 4: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed), 1100 NOR; any other code gives 0
- `MdStartE` in 1: start a multiply/divide
- `MdOpE` in 1: 0 = MULTU, 1 = DIVU
- `ResSelE` in 2: 00 = ALU, 01 = HI, 10 = LO, 11 = ALU
- `ALUOutM` out WIDTH: registered EX result; also the internal forwarding source
- `WriteDataM` out WIDTH: registered forwarded B operand
- `WriteRegM` out REGW: registered destination
- `RegWriteM` out 1: registered write enable
- `ZeroE` out 1: combinational, ALU result == 0
- `StallE` out 1: combinational; the hazard unit holds IF/ID/EX while it is high
- `MdBusy` out 1: multiply/divide unit iterating

## Operation

- SrcA = mux(ForwardAE). WriteDataE = mux(ForwardBE). SrcB = ALUSrcE ? SignImmE : WriteDataE.
- WriteRegE = RegDstE ? RdE : RtE.
- SLT compares signed two's complement and gives 1 or 0, zero-extended. ADD and SUB wrap modulo 2^WIDTH; no overflow trap.
- ExResult = ALU, HI or LO, according to ResSelE.
- `StallE` = MdBusy & (MdStartE | ResSelE==01 | ResSelE==10).
- On each clock edge the EX/MEM register loads ExResult, WriteDataE, WriteRegE and RegWriteE.
- When `StallE` = 1 the register loads a bubble instead: `RegWriteM`=0, `WriteRegM`=0, data fields 0.
- Multiply/divide state machine, states IDLE, MUL, DIV:
  - IDLE → MUL or DIV when `MdStartE` = 1 and `StallE` = 0. Operands latch from SrcA and WriteDataE (forwarded values; ALUSrc is ignored). Counter loads WIDTH. `MdBusy` rises.
  - MUL: shift-add, one multiplier bit per cycle. Product is 2·WIDTH bits; HI = upper half, LO = lower half.
  - DIV: restoring division, one quotient bit per cycle. LO = quotient, HI = remainder.
  - Counter decrements each cycle. On the edge where it reaches 0, HI/LO update, the machine returns to IDLE and `MdBusy` falls.
- Divide by zero is not an error. It runs the full WIDTH cycles and yields LO = all ones, HI = dividend.
- HI/LO change only at completion. They are never partially updated.
- There is no abort. `MdStartE` while busy only stalls; the start is taken after completion.
- Reset mid-operation: the state machine returns to IDLE immediately, the counter clears, HI=LO=0, and the partial result is discarded.

## Timing

- Reset values: `ALUOutM`=0, `WriteDataM`=0, `WriteRegM`=0, `RegWriteM`=0, `MdBusy`=0, HI=0, LO=0, state IDLE. `StallE` and `ZeroE` then follow their combinational inputs.
- ALU path: 1-cycle latency, EX inputs to M outputs.
- Multiply/divide: start sampled at edge T0. `MdBusy`=1 from just after T0 through T0+WIDTH. HI/LO are readable without stall in the cycle after T0+WIDTH.
- Back-to-back starts: a start presented in the first cycle after completion is accepted at that cycle's edge.
- A HI/LO read issued in the same cycle as a start sees the old HI/LO; busy is not yet high.

## Test plan

- Forwarding: RD1_E=5, ALUOutM-path previous result=7, ForwardAE=10, SrcB = Imm 3, ADD → `ALUOutM`=10 one cycle later. Repeat with ForwardAE=01, ResultW=9 → 12.
- ALU ops: SLT with A=0xFFFFFFFF, B=1 → 1. SUB 3−3 → `ZeroE`=1, result 0. NOR 0,0 → 0xFFFFFFFF. Code 1111 → 0.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `MdBusy` high 32 cycles, then HI=0xFFFFFFFE, LO=0x00000001. ResSel=LO issued while busy → `StallE`=1 and bubbles (`RegWriteM`=0) until done, then LO is delivered.
- DIVU 100 ÷ 7 → LO=14, HI=2 after 32 cycles. DIVU 55 ÷ 0 → LO=0xFFFFFFFF, HI=55.
- Second start during busy → stalled, then accepted the cycle after completion; `MdBusy` gap is exactly 1 cycle low.
- Assert `rst` 10 cycles into a MULTU → `MdBusy`=0, HI=LO=0 and all M outputs 0 immediately, without waiting for a clock edge. After release a fresh MULTU 6×7 gives LO=42, HI=0.

Source files
------------

// File: rtl/ex_stage_md.sv
// ---------------------------------------------------------------------------
// ex_stage_md
//
// Execute stage of the pipelined MIPS core with the EX/MEM pipeline register
// folded in. Contains the operand-forwarding muxes, the ALUSrc mux, the ALU,
// an iterative unsigned multiply/divide unit with HI/LO registers, and the
// stall request that holds IF/ID/EX while the unit is busy.
//
// Ports
//   clk, rst           clock (rising edge), asynchronous active-high reset
//   RD1_E, RD2_E       register-file operands
//   SignImmE           sign-extended immediate
//   ResultW            writeback result (forwarding source)
//   ForwardAE/BE       forwarding select: 00 RD, 01 ResultW, 10 ALUOutM, 11 RD
//   RtE, RdE           destination candidates
//   RegDstE, ALUSrcE, RegWriteE   decoded controls
//   ALUControlE        ALU operation code
//   MdStartE, MdOpE    start multiply/divide; 0 = MULTU, 1 = DIVU
//   ResSelE            result select: 00 ALU, 01 HI, 10 LO, 11 ALU
//   ALUOutM, WriteDataM, WriteRegM, RegWriteM   EX/MEM register outputs
//   ZeroE              combinational ALU-result-is-zero flag
//   StallE             combinational stall request to the hazard unit
//   MdBusy             multiply/divide unit iterating
//
// Multiply/divide FSM
//   state  | meaning
//   IDLE   | no operation in flight; HI/LO hold the last completed result
//   MUL    | shift-add multiply, one multiplier bit per cycle
//   DIV    | restoring divide, one quotient bit per cycle
// ---------------------------------------------------------------------------
module ex_stage_md #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] RD1_E,
  input  logic [WIDTH-1:0] RD2_E,
  input  logic [WIDTH-1:0] SignImmE,
  input  logic [WIDTH-1:0] ResultW,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [REGW-1:0]  RtE,
  input  logic [REGW-1:0]  RdE,
  input  logic             RegDstE,
  input  logic             ALUSrcE,
  input  logic             RegWriteE,
  input  logic [3:0]       ALUControlE,
  input  logic             MdStartE,
  input  logic             MdOpE,
  input  logic [1:0]       ResSelE,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [REGW-1:0]  WriteRegM,
  output logic             RegWriteM,
  output logic             ZeroE,
  output logic             StallE,
  output logic             MdBusy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] write_data_e;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] alu_result;
  logic [WIDTH-1:0] ex_result;
  logic [REGW-1:0]  write_reg_e;
  logic             slt_bit;

  logic [1:0]       state_q, state_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  // acc: product upper half (MUL) or partial remainder (DIV)
  // sh:  multiplier / product lower half (MUL) or dividend / quotient (DIV)
  // opnd: multiplicand (MUL) or divisor (DIV)
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_next;
  logic [WIDTH-1:0] mul_sh_next;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] div_acc_next;
  logic [WIDTH-1:0] div_sh_next;

  // -------------------------------------------------------------------------
  // Operand selection
  // -------------------------------------------------------------------------
  always_comb begin
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALUOutM;
      default: src_a = RD1_E;
    endcase
  end

  always_comb begin
    case (ForwardBE)
      2'b01:   write_data_e = ResultW;
      2'b10:   write_data_e = ALUOutM;
      default: write_data_e = RD2_E;
    endcase
  end

  assign src_b       = ALUSrcE ? SignImmE : write_data_e;
  assign write_reg_e = RegDstE ? RdE : RtE;

  // -------------------------------------------------------------------------
  // ALU
  // -------------------------------------------------------------------------
  assign slt_bit = ($signed(src_a) < $signed(src_b));

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      4'b0000: alu_result = src_a & src_b;
      4'b0001: alu_result = src_a | src_b;
      4'b0010: alu_result = src_a + src_b;
      4'b0110: alu_result = src_a - src_b;
      4'b0111: alu_result = {{(WIDTH-1){1'b0}}, slt_bit};
      4'b1100: alu_result = ~(src_a | src_b);
      default: alu_result = '0;
    endcase
  end

  assign ZeroE = (alu_result == '0);

  always_comb begin
    case (ResSelE)
      2'b01:   ex_result = hi_q;
      2'b10:   ex_result = lo_q;
      default: ex_result = alu_result;
    endcase
  end

  assign MdBusy = (state_q != S_IDLE);
  assign StallE = MdBusy & (MdStartE | (ResSelE == 2'b01) | (ResSelE == 2'b10));

  // -------------------------------------------------------------------------
  // Multiply/divide datapath, one bit per cycle
  // -------------------------------------------------------------------------
  // Shift-add: add the multiplicand when the current multiplier bit is set,
  // then shift the whole {acc, sh} pair right by one. The carry out of the
  // add becomes the new top bit of acc.
  assign mul_sum      = {1'b0, acc_q} + (sh_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_acc_next = mul_sum[WIDTH:1];
  assign mul_sh_next  = {mul_sum[0], sh_q[WIDTH-1:1]};

  // Restoring divide: bring in the next dividend bit, subtract the divisor
  // if it fits. A zero divisor always "fits", giving an all-ones quotient
  // and leaving the dividend as the remainder.
  assign div_shift    = {acc_q, sh_q[WIDTH-1]};
  assign div_diff     = div_shift - {1'b0, opnd_q};
  assign div_ge       = (div_shift >= {1'b0, opnd_q});
  assign div_acc_next = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_sh_next  = {sh_q[WIDTH-2:0], div_ge};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    acc_d   = acc_q;
    sh_d    = sh_q;
    opnd_d  = opnd_q;
    case (state_q)
      S_IDLE: begin
        if (MdStartE && !StallE) begin
          state_d = MdOpE ? S_DIV : S_MUL;
          cnt_d   = CNTW'(WIDTH);
          acc_d   = '0;
          sh_d    = MdOpE ? src_a : write_data_e;
          opnd_d  = MdOpE ? write_data_e : src_a;
        end
      end
      S_MUL: begin
        acc_d = mul_acc_next;
        sh_d  = mul_sh_next;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          hi_d    = mul_acc_next;
          lo_d    = mul_sh_next;
          state_d = S_IDLE;
        end
      end
      S_DIV: begin
        acc_d = div_acc_next;
        sh_d  = div_sh_next;
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          hi_d    = div_acc_next;
          lo_d    = div_sh_next;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      acc_q   <= acc_d;
      sh_q    <= sh_d;
      opnd_q  <= opnd_d;
    end
  end

  // -------------------------------------------------------------------------
  // EX/MEM register; a stalled cycle inserts an all-zero bubble
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
      RegWriteM  <= 1'b0;
    end else if (StallE) begin
      ALUOutM    <= '0;
      WriteDataM <= '0;
      WriteRegM  <= '0;
      RegWriteM  <= 1'b0;
    end else begin
      ALUOutM    <= ex_result;
      WriteDataM <= write_data_e;
      WriteRegM  <= write_reg_e;
      RegWriteM  <= RegWriteE;
    end
  end

endmodule
